aes128_inv_cipher_top: RTL

Iterative AES-128 inverse cipher (decryption) that pairs with the encrypt top. It accepts a 128-bit cipher key and ciphertext, derives the last round key internally, then runs one inverse round per `clk_sys` cycle, generating round keys in reverse order on the fly. It delivers the plaintext with a one-cycle ready pulse.

---
 rtl/aes128_inv_cipher_top.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_inv_cipher_top.sv
// Iterative AES-128 decryptor: forward key expansion, then one inverse round per clock.
// Optional AES128_KEY_CACHE_EN keeps the last key's round-10 key to skip expansion.
package aes_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                             ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                             ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                             ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_pkg::*;
    logic [7:0] b;
    assign b = gf_inv(a);
    assign y = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_pkg::*;
    logic [7:0] b;
    assign b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    assign y = gf_inv(b);
endmodule

module aes128_inv_cipher_top (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [127:0] cipher_key,
    input  logic [127:0] cipher_text,
    input  logic         decipher_en,
    output logic [127:0] plain_text,
    output logic         decipher_ready,
    output logic         decipher_busy
);
    import aes_pkg::*;

    typedef enum logic [1:0] {IDLE, KEYGEN, ROUND} state_t;

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] key_reg, data_reg;
    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  sb_in, sb_rot, sb_out, f_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rc;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] shifted, sub_bytes, ark, round_out;

    assign {k0, k1, k2, k3} = key_reg;

    // Expansion feeds w[i-1]; inversion recovers w[i-1] as w[i+3]^w[i+2]
    assign sb_in  = (state == ROUND) ? (k3 ^ k2) : k3;
    assign sb_rot = {sb_in[23:0], sb_in[31:24]};
    assign rc     = rcon((state == ROUND) ? rnd + 4'd1 : rnd);
    assign f_word = sb_out ^ {rc, 24'h0};

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        aes_sbox u_sbox (.a(sb_rot[8*g +: 8]), .y(sb_out[8*g +: 8]));
    end

    assign n0 = k0 ^ f_word;
    assign n1 = k1 ^ n0;
    assign n2 = k2 ^ n1;
    assign n3 = k3 ^ n2;
    assign key_fwd = {n0, n1, n2, n3};
    assign key_inv = {k0 ^ f_word, k1 ^ k0, k2 ^ k1, k3 ^ k2};

    assign shifted = inv_shift_rows(data_reg);

    for (genvar g = 0; g < 16; g++) begin : g_dp_sbox
        aes_inv_sbox u_isbox (.a(shifted[8*g +: 8]), .y(sub_bytes[8*g +: 8]));
    end

    assign ark       = sub_bytes ^ key_inv;
    assign round_out = (rnd == 4'd0) ? ark : inv_mix_columns(ark);

`ifdef AES128_KEY_CACHE_EN
    logic [127:0] cache_tag, cache_rk;
    logic         cache_valid;
    logic         cache_hit;
    assign cache_hit = cache_valid && (cipher_key == cache_tag);
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rnd            <= '0;
            key_reg        <= '0;
            data_reg       <= '0;
            plain_text     <= '0;
            decipher_ready <= 1'b0;
            decipher_busy  <= 1'b0;
`ifdef AES128_KEY_CACHE_EN
            cache_tag      <= '0;
            cache_rk       <= '0;
            cache_valid    <= 1'b0;
`endif
        end else begin
            decipher_ready <= 1'b0;
            unique case (state)
                IDLE: if (decipher_en) begin
                    decipher_busy <= 1'b1;
                    key_reg       <= cipher_key;
                    data_reg      <= cipher_text;
                    rnd           <= 4'd1;
                    state         <= KEYGEN;
`ifdef AES128_KEY_CACHE_EN
                    // Tag is claimed now; the entry only turns valid once rk10 exists
                    cache_tag   <= cipher_key;
                    cache_valid <= 1'b0;
                    if (cache_hit) begin
                        key_reg     <= cache_rk;
                        data_reg    <= cipher_text ^ cache_rk;
                        rnd         <= 4'd9;
                        state       <= ROUND;
                        cache_valid <= 1'b1;
                    end
`endif
                end
                KEYGEN: begin
                    key_reg <= key_fwd;
                    if (rnd == 4'd10) begin
                        data_reg <= data_reg ^ key_fwd;
                        rnd      <= 4'd9;
                        state    <= ROUND;
`ifdef AES128_KEY_CACHE_EN
                        cache_rk    <= key_fwd;
                        cache_valid <= 1'b1;
`endif
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ROUND: begin
                    key_reg  <= key_inv;
                    data_reg <= round_out;
                    if (rnd == 4'd0) begin
                        plain_text     <= round_out;
                        decipher_ready <= 1'b1;
                        decipher_busy  <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
